// File: rtl/kgp_pkg.sv
// Shared KGPminiRISC definitions: shift opcodes, default widths and shifter FSM state encoding.
package kgp_pkg;

  localparam int unsigned KGP_WIDTH = 32;
  localparam int unsigned KGP_SHW   = 5;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage : kgp_pkg

// File: rtl/seq_shifter_shift_step.sv
// Single-bit shift datapath for seq_shifter: one step of sll/srl/sra (and ror when
// SEQ_SHIFT_ROT_EN is defined), reporting the bit that falls off.
module shift_step
  import kgp_pkg::*;
#(
  parameter int unsigned WIDTH = KGP_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] d_next,
  output logic             bit_out
);

  always_comb begin
    d_next  = d;
    bit_out = 1'b0;
    case (op)
      SHIFT_OP_SLL: begin
        d_next  = {d[WIDTH-2:0], 1'b0};
        bit_out = d[WIDTH-1];
      end
      SHIFT_OP_SRL: begin
        d_next  = {1'b0, d[WIDTH-1:1]};
        bit_out = d[0];
      end
      SHIFT_OP_SRA: begin
        d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
        bit_out = d[0];
      end
      default: begin
`ifdef SEQ_SHIFT_ROT_EN
        d_next  = {d[0], d[WIDTH-1:1]};
        bit_out = d[0];
`else
        // Pass-through opcode never reaches a shift step; keep the operand intact.
        d_next  = d;
        bit_out = 1'b0;
`endif
      end
    endcase
  end

endmodule : shift_step

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock, result and carry registered for write-back.
// Build option: SEQ_SHIFT_ROT_EN enables op=11 as rotate-right (otherwise a pass-through).
module seq_shifter
  import kgp_pkg::*;
#(
  parameter int unsigned WIDTH = KGP_WIDTH,
  parameter int unsigned SHW   = KGP_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  shift_state_t     state;
  logic [WIDTH-1:0] data_reg;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_reg;
  logic             carry;
  logic [WIDTH-1:0] step_d;
  logic             step_bit;
  logic [SHW-1:0]   shamt_eff_c;

`ifdef SEQ_SHIFT_ROT_EN
  assign shamt_eff_c = shamt;
`else
  // Without rotate support op=11 degenerates to a zero-length shift.
  assign shamt_eff_c = (op == SHIFT_OP_ROR) ? '0 : shamt;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d       (data_reg),
    .op      (op_reg),
    .d_next  (step_d),
    .bit_out (step_bit)
  );

  // Control FSM, shift counter and datapath registers; outputs registered alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      data_reg <= '0;
      cnt      <= '0;
      op_reg   <= SHIFT_OP_SLL;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SHIFT;
            data_reg <= data_in;
            cnt      <= shamt_eff_c;
            op_reg   <= op;
            carry    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            data_reg <= step_d;
            carry    <= step_bit;
            cnt      <= cnt - SHW'(1);
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result    = data_reg;
  assign carry_out = carry;

endmodule : seq_shifter

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: behavioural shift model plus directed literal cases.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  seq_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .shamt     (shamt),
    .data_in   (data_in),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation result: {carry, value} from plain arithmetic on the operand.
  function automatic logic [32:0] exp_shift(input logic [1:0] o, input logic [31:0] d, input int s);
    logic [31:0] r;
    logic        c;
    case (o)
      2'b00: begin r = d << s; c = (s == 0) ? 1'b0 : d[32-s]; end
      2'b01: begin r = d >> s; c = (s == 0) ? 1'b0 : d[s-1]; end
      2'b10: begin r = 32'($signed(d) >>> s); c = (s == 0) ? 1'b0 : d[s-1]; end
      default: begin
`ifdef SEQ_SHIFT_ROT_EN
        r = (d >> s) | (d << (32 - s));
        c = (s == 0) ? 1'b0 : d[s-1];
`else
        r = d;
        c = 1'b0;
`endif
      end
    endcase
    return {c, r};
  endfunction

  function automatic int eff_shamt(input logic [1:0] o, input logic [4:0] s);
`ifdef SEQ_SHIFT_ROT_EN
    return int'(s);
`else
    return (o == 2'b11) ? 0 : int'(s);
`endif
  endfunction

  // Reference: after acceptance, s idle-shift edges, then one edge to raise done, one to drop it.
  logic        m_busy, m_done, m_valid, m_carry;
  logic [31:0] m_res;
  logic [32:0] m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
      m_res   <= '0;
      m_carry <= 1'b0;
      m_left  <= 0;
      m_pend  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 0) begin
        m_done  <= 1'b1;
        m_valid <= 1'b1;
        m_carry <= m_pend[32];
        m_res   <= m_pend[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start) begin
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= eff_shamt(op, shamt);
      m_pend  <= exp_shift(op, data_in, eff_shamt(op, shamt));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (m_valid) begin
        check("result", result, m_res);
        check("carry_out", 32'(carry_out), 32'(m_carry));
      end
    end
  end

  // Directed op: lat is the number of edges after acceptance before done is seen high.
  task automatic run_dir(input string name, input logic [1:0] o, input logic [31:0] d,
                         input logic [4:0] s, input logic [31:0] exp_r, input logic exp_c,
                         input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, result, exp_r);
    check({name, "_carry"}, 32'(carry_out), 32'(exp_c));
    @(negedge clk);
  endtask

  initial begin
    int dones;
    int guard;
    rst = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_carry", 32'(carry_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_dir("sll1",  2'b00, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 2);
    run_dir("sra4",  2'b10, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0, 5);
    run_dir("srl5",  2'b01, 32'h0000_0010, 5'd5, 32'h0000_0000, 1'b1, 6);
    run_dir("sh0",   2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1);
    run_dir("sll31", 2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1, 32);
`ifdef SEQ_SHIFT_ROT_EN
    run_dir("ror1",  2'b11, 32'h0000_0003, 5'd1, 32'h8000_0001, 1'b1, 2);
`else
    run_dir("pass",  2'b11, 32'h0000_0003, 5'd1, 32'h0000_0003, 1'b0, 1);
`endif

    // Start held high: one op every 6 cycles, operand noise while busy must not leak in.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd3; data_in = 32'h1;
    dones = 0;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("held_result", result, 32'h8);
      end
      if (i == 29) start = 1'b0;
      data_in = busy ? $urandom : 32'h1;
    end
    check("held_done_count", 32'(dones), 32'd5);
    data_in = 32'h1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-shift with 10 steps still pending.
    @(negedge clk);
    start = 1'b1; op = 2'b01; shamt = 5'd20; data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_carry", 32'(carry_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_dir("after_rst", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32);

    // Randomised traffic: frequent start requests, including ones while busy.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) != 0);
      op      = 2'($urandom_range(0, 3));
      shamt   = 5'($urandom_range(0, 31));
      data_in = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("drain_idle", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seq_shifter
